// File: rtl/cla_seq_add.sv
// Wide add/subtract that reuses one SLICE-bit carry-lookahead adder over
// WIDTH/SLICE cycles, with valid/ready handshakes on both sides.

module cla_add #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  output logic [BITS-1:0] s,
  output logic            co
);

  logic [BITS-1:0] g;
  logic [BITS-1:0] p;
  logic [BITS:0]   c;
  logic            acc;
  logic            pp;
  int unsigned     j;

  // Each carry is the flat OR of generate terms gated by the propagate run above them.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    acc  = 1'b0;
    pp   = 1'b1;
    j    = 0;
    for (int unsigned i = 1; i <= BITS; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int unsigned n = 0; n < i; n++) begin
        j   = i - 1 - n;
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i] = acc | (pp & ci);
    end
  end

  assign s  = p ^ c[BITS-1:0];
  assign co = c[BITS];

endmodule

module cla_seq_add #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  logic             accept;

  assign sl_a = opa_q[k_q*SLICE +: SLICE];
  assign sl_b = opb_q[k_q*SLICE +: SLICE];

  cla_add #(.BITS(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign out_sum   = sum_q;
  assign out_co    = carry_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;

  // A load can only happen from IDLE or a completing DONE, so it takes priority over the state case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      opa_q   <= in_a;
      opb_q   <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? ~in_ci : in_ci;
      k_q     <= '0;
      state_q <= S_RUN;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          sum_q[k_q*SLICE +: SLICE] <= sl_s;
          carry_q <= sl_co;
          if (k_q == K_LAST) begin
            ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sl_s[SLICE-1] != opa_q[WIDTH-1]);
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_add.sv
// Self-checking bench for cla_seq_add: directed corner cases plus randomized
// handshake traffic against an arithmetic reference model.

module tb_cla_seq_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_sub, in_ci;
  logic        out_valid, out_ready, out_co, out_ovf, busy;
  logic [31:0] in_a, in_b, out_sum;

  logic        x_valid, x_sub, x_ci;
  logic [31:0] x_a, x_b;
  logic        r16, v16, co16, ov16, b16;
  logic        r32, v32, co32, ov32, b32;
  logic [31:0] s16, s32;

  int n_tests = 0;
  int n_fail  = 0;

  cla_seq_add #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_ci(in_ci),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_co(out_co), .out_ovf(out_ovf), .busy(busy)
  );

  cla_seq_add #(.WIDTH(32), .SLICE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r16),
    .in_a(x_a), .in_b(x_b), .in_sub(x_sub), .in_ci(x_ci),
    .out_valid(v16), .out_ready(1'b1), .out_sum(s16),
    .out_co(co16), .out_ovf(ov16), .busy(b16)
  );

  cla_seq_add #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r32),
    .in_a(x_a), .in_b(x_b), .in_sub(x_sub), .in_ci(x_ci),
    .out_valid(v32), .out_ready(1'b1), .out_sum(s32),
    .out_co(co32), .out_ovf(ov32), .busy(b32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic; returns {ovf, co, sum}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic ci);
    longint ua, ub, uc, sa, sb, u, s, lim;
    logic   co, ovf;
    ua  = a;
    ub  = b;
    uc  = ci;
    sa  = $signed(a);
    sb  = $signed(b);
    lim = 64'sh8000_0000;
    if (!sub) begin
      u  = ua + ub + uc;
      s  = sa + sb + uc;
      co = (u >= 64'sh1_0000_0000);
    end else begin
      u  = ua - ub - uc;
      s  = sa - sb - uc;
      co = (u >= 0);
    end
    ovf = (s >= lim) || (s < -lim);
    return {ovf, co, u[31:0]};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // Called at the first falling edge after acceptance; returns edges-to-valid and busy count.
  task automatic wait_done(output int edges, output int bc);
    int i;
    i  = 1;
    bc = 0;
    while (!out_valid && i < 30) begin
      if (busy) bc++;
      @(negedge clk);
      i++;
    end
    edges = i - 1;
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic ci,
                          input logic [31:0] esum, input logic eco, input logic eovf);
    logic [33:0] m;
    int e, bc;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_ci = ci;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(e, bc);
    check({tag, "_latency"}, e, 4);
    check({tag, "_busy_cycles"}, bc, 4);
    check({tag, "_sum"}, out_sum, esum);
    check({tag, "_co"}, out_co, eco);
    check({tag, "_ovf"}, out_ovf, eovf);
    m = model(a, b, sub, ci);
    check({tag, "_model"}, {out_ovf, out_co, out_sum}, m);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] m, m2;
    logic [33:0] expq[$];
    int e, bc, accepted, retired, cyc;
    logic have;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_ci = 1'b0;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_sub = 1'b0; x_ci = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_co", out_co, 0);
    check("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_bin", 32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0);

    // Backpressure with a second request held valid throughout.
    m  = model(32'h1234_ABCD, 32'h0F0F_0F0F, 1'b0, 1'b1);
    m2 = model(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
    @(negedge clk);
    in_a = 32'h1234_ABCD; in_b = 32'h0F0F_0F0F; in_sub = 1'b0; in_ci = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_sub = 1'b1; in_ci = 1'b0;
    wait_done(e, bc);
    check("bp_latency", e, 4);
    for (int unsigned c = 0; c < 10; c++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", {out_ovf, out_co, out_sum}, m);
      check("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_follows", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_overlap_busy", busy, 1);
    check("bp_overlap_valid", out_valid, 0);
    wait_done(e, bc);
    check("bp_next_latency", e, 4);
    check("bp_next_result", {out_ovf, out_co, out_sum}, m2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while the third slice is in flight.
    in_a = 32'hDEAD_BEEF; in_b = 32'h0123_4567; in_sub = 1'b0; in_ci = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_co", out_co, 0);
    check("midrst_ovf", out_ovf, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    directed("postrst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Random traffic with gaps on both handshakes.
    accepted = 0; retired = 0; cyc = 0; have = 1'b0;
    while ((accepted < 2000 || expq.size() > 0) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (!have && accepted < 2000) begin
        in_a = rnd_word(); in_b = rnd_word();
        in_sub = 1'($urandom_range(0, 1)); in_ci = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7) || (accepted >= 2000);
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("rnd_spurious_result", out_valid, 0);
        end else begin
          m = expq.pop_front();
          check("rnd_result", {out_ovf, out_co, out_sum}, m);
          retired++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(in_a, in_b, in_sub, in_ci));
        accepted++;
        have = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rnd_retired", retired, 2000);
    check("rnd_accepted", accepted, 2000);

    // Wider slices: 2-slice and single-slice variants in lockstep.
    for (int unsigned t = 0; t < 60; t++) begin
      logic g16, g32;
      int e16, e32, i;
      @(negedge clk);
      x_a = rnd_word(); x_b = rnd_word();
      x_sub = 1'($urandom_range(0, 1)); x_ci = 1'($urandom_range(0, 1));
      m = model(x_a, x_b, x_sub, x_ci);
      x_valid = 1'b1;
      #1;
      check("x_in_ready", {r16, r32}, 2'b11);
      @(negedge clk);
      x_valid = 1'b0;
      g16 = 1'b0; g32 = 1'b0; e16 = -1; e32 = -1; i = 1;
      while (!(g16 && g32) && i < 10) begin
        if (v16 && !g16) begin
          g16 = 1'b1; e16 = i - 1;
          check("x16_result", {ov16, co16, s16}, m);
        end
        if (v32 && !g32) begin
          g32 = 1'b1; e32 = i - 1;
          check("x32_result", {ov32, co32, s32}, m);
        end
        @(negedge clk);
        i++;
      end
      check("x16_latency", e16, 2);
      check("x32_latency", e32, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_add.md
# cla_seq_add

Multi-cycle wide-word add/subtract controller built around a single `cla_add` slice of SLICE bits. It time-multiplexes that one slice over NSLICE = WIDTH/SLICE cycles, chaining the carry through a register. This trades latency for area when wide integer or mantissa adds are infrequent. It sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, width of the instantiated `cla_add` (its BITS).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands on in_a/in_b/in_sub/in_ci are valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: A+B+ci; 1: A−B−ci.
- in_ci  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  result fields valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_co  out  1  final carry out of the MSB slice (sub: 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN.

## Operation
- Registers: state, slice counter k (ceil(log2 NSLICE) bits, min 1), opA, opB' (B, or ~B when sub), carry, sum.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch opA=in_a and opB'=in_sub ? ~in_b : in_b.
  - Set carry = in_sub ? ~in_ci : in_ci, and k=0.
  - Go to RUN.
- State RUN:
  - Slice k of opA/opB' plus carry drive `cla_add` combinationally.
  - At the edge, write s into sum[k*SLICE +: SLICE] and write co into carry.
  - If k==NSLICE−1, capture out_ovf = (opA[MSB]==opB'[MSB]) && (s[SLICE−1]!=opA[MSB]), then go to DONE. Otherwise k←k+1.
  - in_ready=0 throughout RUN; RUN cannot be aborted except by reset.
- State DONE:
  - out_valid=1, with out_sum=sum, out_co=carry, and out_ovf as registered.
  - Outputs stay stable until out_ready.
  - in_ready = out_ready.
  - On out_valid&out_ready: if in_valid also high, the new operation is accepted on the same edge (DONE→RUN). Otherwise go to IDLE.
- Unspecified states go to IDLE.
- in_* are ignored when in_ready=0. out_ready is ignored outside DONE.
- NSLICE==1 is legal: RUN lasts one cycle.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, k=0, carry=0, sum=0, out_ovf=0.
  - Hence out_valid=0, out_sum=0, out_co=0, out_ovf=0, busy=0, in_ready=1.
- Reset mid-RUN or in DONE drops the operation with no output. The first operation after reset behaves normally.
- Latency: if the input is accepted at edge E0, out_valid rises after edge E0+NSLICE. For 32/8 that is 4 cycles.
- Throughput with out_ready held high and in_valid continuous: one result per NSLICE+1 cycles (DONE overlaps acceptance).
- With out_ready low, DONE holds indefinitely and nothing is lost.
- busy = (state==RUN). in_ready and out_valid are decoded from state registers only; there is no combinational path from in_valid to any output.
- in_ready depends combinationally on out_ready only in DONE.

## Test plan
- Add carry ripple: 32/8, a=0xFFFF_FFFF, b=0x0000_0001, sub=0, ci=0 → sum=0x0000_0000, co=1, ovf=0; out_valid exactly 4 cycles after accept, busy high 4 cycles.
- Signed overflow: a=0x7FFF_FFFF, b=1, add → sum=0x8000_0000, co=0, ovf=1. Then a=0x8000_0000, b=0xFFFF_FFFF, add → sum=0x7FFF_FFFF, co=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, ci=0 → sum=0xFFFF_FFFE, co=0, ovf=0. Then a=7, b=5, sub=1, ci=1 → sum=1, co=1.
- Backpressure/overlap: hold out_ready=0 for 10 cycles in DONE → out_valid, out_sum, out_co, out_ovf stable, in_ready=0, held in_valid not accepted. Raise out_ready → result and next input both handshake on the same edge; the next out_valid appears 4 cycles later.
- Reset mid-RUN: assert rst_n=0 while k=2 → outputs take reset values immediately, in_ready=1 after release. Next op a=0x1234_5678, b=0x1111_1111 → 0x2345_6789.
- Random: 2000 ops with random a/b/sub/ci, random in_valid/out_ready gaps, SLICE∈{8,16,32}, WIDTH=32 → every sum, co and ovf matches a behavioural model; no drops or duplicates.
